// File: rtl/reg_serial_reader_pkg.sv
// -----------------------------------------------------------------------------
// reg_reader_pkg
//   Shared definitions for the register serial reader:
//     - state_e   : frame FSM states (IDLE, SHIFT, DONE)
//     - cnt_width : width of a counter that must hold 0..n-1, never below 1 bit
// -----------------------------------------------------------------------------
package reg_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // max(1, $clog2(n)): a DIV of 1 still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_serial_reader_if.sv
// -----------------------------------------------------------------------------
// reg_serial_reader_if
//   Request/readback bundle between a register bank consumer and the serial
//   reader.
//     rd_req    : level request to snapshot reg_in
//     reg_in    : parallel register value (WIDTH bits)
//     rd_ack    : one-cycle pulse, snapshot taken
//     busy      : frame in progress (capture cycle through DONE)
//     ser_out   : serial data bit, 0 when ser_valid is low
//     ser_valid : a bit is being driven
//     ser_last  : final bit of the frame is being driven
//     done      : one-cycle pulse after the final bit
//   Modports: master (requester side), slave (reader side).
// -----------------------------------------------------------------------------
interface reg_serial_reader_if #(
    parameter int unsigned WIDTH = 8
);
    logic             rd_req;
    logic [WIDTH-1:0] reg_in;
    logic             rd_ack;
    logic             busy;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             done;

    modport master (
        output rd_req,
        output reg_in,
        input  rd_ack,
        input  busy,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  done
    );

    modport slave (
        input  rd_req,
        input  reg_in,
        output rd_ack,
        output busy,
        output ser_out,
        output ser_valid,
        output ser_last,
        output done
    );
endinterface

// File: rtl/reg_serial_reader_bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
//   Bit-period divider. Counts 0..DIV-1 while clear is low and raises tick
//   during the terminal count cycle; the counter then wraps to 0.
//     clk   : clock, rising edge
//     rst   : synchronous active-high reset
//     clear : hold counter at 0 (and suppress tick)
//     tick  : one-cycle pulse on the terminal count
// -----------------------------------------------------------------------------
module bit_tick_gen
    import reg_reader_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = cnt_width(DIV);
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
        end else if (div_cnt == TERM) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // With DIV=1 the counter sits at 0 == TERM, so tick fires every cycle.
    assign tick = !clear && (div_cnt == TERM);

endmodule

// File: rtl/reg_serial_reader.sv
// -----------------------------------------------------------------------------
// reg_serial_reader
//   Snapshots a WIDTH-bit register value on request and streams it out one bit
//   per DIV-cycle bit period, MSB or LSB first.
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : reg_serial_reader_if.slave (rd_req, reg_in in; rd_ack, busy,
//           ser_out, ser_valid, ser_last, done out)
//   Parameters: WIDTH (>=2), DIV (>=1), MSB_FIRST (1: bit WIDTH-1 first).
//   Frame: capture edge t, bits on cycles t+1..t+WIDTH*DIV, done on the next
//   cycle, then one IDLE cycle before another capture can happen.
// -----------------------------------------------------------------------------
module reg_serial_reader
    import reg_reader_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV       = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_serial_reader_if.slave   bus
);
    localparam int unsigned BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic             tick;
    logic             div_clear;

    logic rd_ack_nxt;
    logic busy_nxt;
    logic ser_out_nxt;
    logic ser_valid_nxt;
    logic ser_last_nxt;
    logic done_nxt;

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    // Divider only runs while shifting; it sits at 0 otherwise so the first
    // bit of every frame gets a full DIV cycles.
    assign div_clear = (state != SHIFT);

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .tick  (tick)
    );

    // Next-state logic. Outputs are registered from the next-state values so
    // they line up with the state they describe without any input-to-output
    // combinational path.
    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift_reg;
        bit_nxt    = bit_cnt;
        rd_ack_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rd_req) begin
                    shift_nxt  = bus.reg_in;
                    bit_nxt    = '0;
                    state_nxt  = SHIFT;
                    rd_ack_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shift_nxt = shift_one(shift_reg);
                    if (bit_cnt == LAST_BIT) begin
                        bit_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt      = (state_nxt != IDLE);
        ser_valid_nxt = (state_nxt == SHIFT);
        ser_out_nxt   = (state_nxt == SHIFT) ? head_bit(shift_nxt) : 1'b0;
        ser_last_nxt  = (state_nxt == SHIFT) && (bit_nxt == LAST_BIT);
        done_nxt      = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            bus.rd_ack    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.ser_out   <= 1'b0;
            bus.ser_valid <= 1'b0;
            bus.ser_last  <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_nxt;
            shift_reg     <= shift_nxt;
            bit_cnt       <= bit_nxt;
            bus.rd_ack    <= rd_ack_nxt;
            bus.busy      <= busy_nxt;
            bus.ser_out   <= ser_out_nxt;
            bus.ser_valid <= ser_valid_nxt;
            bus.ser_last  <= ser_last_nxt;
            bus.done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_reg_serial_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_serial_reader
//   Directed bench for reg_serial_reader with three configurations:
//     u_a : WIDTH=8 DIV=1 MSB first
//     u_b : WIDTH=8 DIV=3 MSB first
//     u_c : WIDTH=8 DIV=2 LSB first
//   Expected per-cycle outputs are hand-written bit masks (bit c = cycle c,
//   cycle c+1 being the one after capture edge c).
// -----------------------------------------------------------------------------
module tb_reg_serial_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_serial_reader_if #(.WIDTH(8)) bus_a ();
    reg_serial_reader_if #(.WIDTH(8)) bus_b ();
    reg_serial_reader_if #(.WIDTH(8)) bus_c ();

    reg_serial_reader #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    reg_serial_reader #(.WIDTH(8), .DIV(3), .MSB_FIRST(1)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    reg_serial_reader #(.WIDTH(8), .DIV(2), .MSB_FIRST(0)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

    // {rd_ack, busy, ser_valid, ser_out, ser_last, done}
    logic [5:0] obs_a, obs_b, obs_c;
    assign obs_a = {bus_a.rd_ack, bus_a.busy, bus_a.ser_valid, bus_a.ser_out, bus_a.ser_last, bus_a.done};
    assign obs_b = {bus_b.rd_ack, bus_b.busy, bus_b.ser_valid, bus_b.ser_out, bus_b.ser_last, bus_b.done};
    assign obs_c = {bus_c.rd_ack, bus_c.busy, bus_c.ser_valid, bus_c.ser_out, bus_c.ser_last, bus_c.done};

    task automatic chk(input string tag, input int c, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle %0d: got ack/busy/val/out/last/done=%b want %b", tag, c, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v);
        case (sel)
            0: bus_a.rd_req = v;
            1: bus_b.rd_req = v;
            default: bus_c.rd_req = v;
        endcase
    endtask

    task automatic set_dat(input int sel, input logic [7:0] v);
        case (sel)
            0: bus_a.reg_in = v;
            1: bus_b.reg_in = v;
            default: bus_c.reg_in = v;
        endcase
    endtask

    // Starts at a negedge in cycle 0. Each iteration checks cycle c, then sets
    // inputs that the edge closing cycle c will sample. rd_req rises at c=0.
    // Negative schedule values disable that event.
    task automatic run(input string tag, input int sel, input int ncyc,
                       input int req_off, input int req2, input int ff_at, input int rst_at,
                       input logic [7:0] dat,
                       input logic [31:0] e_ack, input logic [31:0] e_busy,
                       input logic [31:0] e_val, input logic [31:0] e_out,
                       input logic [31:0] e_last, input logic [31:0] e_done);
        logic [5:0] obs;
        set_dat(sel, dat);
        for (int c = 0; c < ncyc; c++) begin
            case (sel)
                0: obs = obs_a;
                1: obs = obs_b;
                default: obs = obs_c;
            endcase
            chk(tag, c, obs, {e_ack[c], e_busy[c], e_val[c], e_out[c], e_last[c], e_done[c]});
            if (c == 0) set_req(sel, 1'b1);
            if (c == req_off) set_req(sel, 1'b0);
            if (req2 >= 0 && c == req2) set_req(sel, 1'b1);
            if (req2 >= 0 && c == req2 + 1) set_req(sel, 1'b0);
            if (c == ff_at) set_dat(sel, 8'hFF);
            if (c == rst_at) rst = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        bus_a.rd_req = 1'b0; bus_a.reg_in = '0;
        bus_b.rd_req = 1'b0; bus_b.reg_in = '0;
        bus_c.rd_req = 1'b0; bus_c.reg_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_a", 0, obs_a, 6'b0);
        chk("reset_b", 0, obs_b, 6'b0);
        chk("reset_c", 0, obs_c, 6'b0);

        // 0xA5 MSB first, DIV=1: bits 1,0,1,0,0,1,0,1 on cycles 1..8
        run("msb_div1", 0, 12, 1, -1, -1, -1, 8'hA5,
            32'h2, 32'h3FE, 32'h1FE, 32'h14A, 32'h100, 32'h200);

        // reg_in -> 0xFF after capture, extra rd_req at cycle 4 ignored
        run("snapshot", 0, 12, 1, 4, 2, -1, 8'hA5,
            32'h2, 32'h3FE, 32'h1FE, 32'h14A, 32'h100, 32'h200);

        // rd_req held: frames at 1..9 and 11..19
        run("back2back", 0, 21, 20, -1, -1, -1, 8'hA5,
            32'h802, 32'hFFBFE, 32'h7F9FE, 32'h5294A, 32'h40100, 32'h80200);

        // reset sampled at edge 5: cycles 6.. all zero, no further activity
        run("rst_mid", 0, 12, 1, -1, -1, 5, 8'hA5,
            32'h2, 32'h3E, 32'h3E, 32'h0A, 32'h0, 32'h0);

        // full fresh frame after the mid-frame reset
        run("fresh", 0, 12, 1, -1, -1, -1, 8'hA5,
            32'h2, 32'h3FE, 32'h1FE, 32'h14A, 32'h100, 32'h200);

        // 0x81, DIV=3: ser_out high 1-3 and 22-24, done at 25
        run("div3", 1, 27, 1, -1, -1, -1, 8'h81,
            32'h2, 32'h3FFFFFE, 32'h1FFFFFE, 32'h1C0000E, 32'h1C00000, 32'h2000000);

        // 0x01 LSB first, DIV=2: ser_out high 1-2, last 15-16, done 17
        run("lsb_div2", 2, 19, 1, -1, -1, -1, 8'h01,
            32'h2, 32'h3FFFE, 32'h1FFFE, 32'h6, 32'h18000, 32'h20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
